// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - switch inputs and lamp outputs of the traffic light controller
interface traffic_light_ctrl_if #(
  parameter int N_DIR = 2
);
  localparam int PW = (N_DIR > 2) ? $clog2(N_DIR) : 1;

  logic                 night_mode;
  logic                 ped_req;
  logic                 hold;
  logic [3*N_DIR-1:0]   lights;
  logic                 walk;
  logic [PW-1:0]        phase;
  logic                 heartbeat;

  modport master (
    output night_mode, ped_req, hold,
    input  lights, walk, phase, heartbeat
  );

  modport slave (
    input  night_mode, ped_req, hold,
    output lights, walk, phase, heartbeat
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - N-way traffic light sequencer with walk, night flash and green hold
// Phases rotate green/yellow/all-red per approach; outputs are registered from the current state.
module traffic_light_ctrl #(
  parameter int N_DIR    = 2,
  parameter int TICK_DIV = 100_000_000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave tl
);
  localparam int PW    = (N_DIR > 2) ? $clog2(N_DIR) : 1;
  localparam int DW    = $clog2(TICK_DIV);
  localparam int TM_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int TM_AW = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int TMAX  = (TM_GY > TM_AW) ? TM_GY : TM_AW;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_T - 1);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  logic [1:0]         night_sync_q, ped_sync_q, hold_sync_q;
  logic               night_s, ped_s, hold_s;
  logic [DW-1:0]      div_cnt_q;
  logic               tick;
  logic               heartbeat_q;
  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               ped_latch_q, ped_latch_d;
  logic               flash_ph_q, flash_ph_d;
  logic [3*N_DIR-1:0] lights_q, lights_d, all_red;
  logic               walk_q, walk_d;
  logic [PW-1:0]      phase_out_q;

  assign night_s = night_sync_q[1];
  assign ped_s   = ped_sync_q[1];
  assign hold_s  = hold_sync_q[1];
  assign tick    = (div_cnt_q == DW'(TICK_DIV - 1));

  always_comb begin
    all_red = '0;
    for (int i = 0; i < N_DIR; i++) begin
      all_red[3*i+2] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      night_sync_q <= '0;
      ped_sync_q   <= '0;
      hold_sync_q  <= '0;
      div_cnt_q    <= '0;
      heartbeat_q  <= 1'b0;
      state_q      <= S_ALLRED;
      tmr_q        <= ALLRED_LD;
      phase_q      <= '0;
      ped_latch_q  <= 1'b0;
      flash_ph_q   <= 1'b0;
      lights_q     <= all_red;
      walk_q       <= 1'b0;
      phase_out_q  <= '0;
    end else begin
      night_sync_q <= {night_sync_q[0], tl.night_mode};
      ped_sync_q   <= {ped_sync_q[0], tl.ped_req};
      hold_sync_q  <= {hold_sync_q[0], tl.hold};
      div_cnt_q    <= tick ? '0 : div_cnt_q + DW'(1);
      heartbeat_q  <= heartbeat_q ^ tick;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      phase_q      <= phase_d;
      ped_latch_q  <= ped_latch_d;
      flash_ph_q   <= flash_ph_d;
      lights_q     <= lights_d;
      walk_q       <= walk_d;
      phase_out_q  <= phase_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    phase_d     = phase_q;
    flash_ph_d  = flash_ph_q;
    ped_latch_d = ped_latch_q | ped_s;
    case (state_q)
      S_ALLRED: begin
        if (tick) begin
          if (tmr_q == '0) begin
            // Night mode outranks a pending walk; the latch survives the flash period.
            if (night_s) begin
              state_d = S_FLASH;
            end else if (ped_latch_q) begin
              state_d     = S_WALK;
              tmr_d       = WALK_LD;
              ped_latch_d = 1'b0;
            end else begin
              state_d = S_GREEN;
              tmr_d   = GREEN_LD;
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      S_GREEN: begin
        if (tick && !hold_s) begin
          if (tmr_q == '0) begin
            state_d = S_YELLOW;
            tmr_d   = YELLOW_LD;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      S_YELLOW: begin
        if (tick) begin
          if (tmr_q == '0) begin
            state_d = S_ALLRED;
            tmr_d   = ALLRED_LD;
            phase_d = (phase_q == PW'(N_DIR - 1)) ? '0 : phase_q + PW'(1);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      S_WALK: begin
        if (tick) begin
          if (tmr_q == '0) begin
            state_d = S_GREEN;
            tmr_d   = GREEN_LD;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      S_FLASH: begin
        if (tick) begin
          flash_ph_d = ~flash_ph_q;
          if (!night_s) begin
            state_d    = S_ALLRED;
            tmr_d      = ALLRED_LD;
            phase_d    = '0;
            flash_ph_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = S_ALLRED;
        tmr_d      = ALLRED_LD;
        phase_d    = '0;
        flash_ph_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    logic [2:0] lamp;
    lights_d = '0;
    lamp     = 3'b100;
    for (int i = 0; i < N_DIR; i++) begin
      lamp = 3'b100;
      case (state_q)
        S_GREEN:  if (phase_q == PW'(i)) lamp = 3'b001;
        S_YELLOW: if (phase_q == PW'(i)) lamp = 3'b010;
        S_FLASH:  lamp = {1'b0, flash_ph_q, 1'b0};
        default:  lamp = 3'b100;
      endcase
      lights_d[3*i +: 3] = lamp;
    end
  end

  assign walk_d = (state_q == S_WALK);

  assign tl.lights    = lights_q;
  assign tl.walk      = walk_q;
  assign tl.phase     = phase_out_q;
  assign tl.heartbeat = heartbeat_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - table-driven bench for the traffic light controller
module tb_traffic_light_ctrl;
  localparam logic [5:0] R  = 6'b100100;
  localparam logic [5:0] G0 = 6'b100001;
  localparam logic [5:0] Y0 = 6'b100010;
  localparam logic [5:0] G1 = 6'b001100;
  localparam logic [5:0] Y1 = 6'b010100;
  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [5:0] F1 = 6'b010010;

  typedef struct {
    logic       rst;
    logic       night;
    logic       ped;
    logic       hold;
    int         n;
    logic [5:0] lights;
    logic       walk;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   k;
  int   sc;
  vec_t vecs[$];
  vec_t post[$];

  traffic_light_ctrl_if #(.N_DIR(2)) tl ();

  traffic_light_ctrl #(
    .N_DIR(2), .TICK_DIV(4), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tl    (tl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic nm, input logic p, input logic h,
                              input int n, input logic [5:0] l, input logic w);
    vec_t v;
    v.rst = r; v.night = nm; v.ped = p; v.hold = h; v.n = n; v.lights = l; v.walk = w;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    checks++;
    if (tl.lights !== R || tl.walk !== 1'b0 || tl.heartbeat !== 1'b0 || tl.phase !== 1'b0) begin
      failures++;
      $display("FAIL %s sc=%0d got lights=%b walk=%b hb=%b phase=%b exp lights=%b walk=0 hb=0 phase=0",
               tag, sc, tl.lights, tl.walk, tl.heartbeat, tl.phase, R);
    end
  endtask

  task automatic check_cycle(input logic [5:0] el, input logic ew);
    logic ehb;
    int   nonred;
    logic safe;
    ehb = ((k / 4) % 2) == 1;
    checks++;
    if (tl.lights !== el) begin
      failures++;
      $display("FAIL lights sc=%0d k=%0d got=%b exp=%b", sc, k, tl.lights, el);
    end
    checks++;
    if (tl.walk !== ew) begin
      failures++;
      $display("FAIL walk sc=%0d k=%0d got=%b exp=%b", sc, k, tl.walk, ew);
    end
    checks++;
    if (tl.heartbeat !== ehb) begin
      failures++;
      $display("FAIL heartbeat sc=%0d k=%0d got=%b exp=%b", sc, k, tl.heartbeat, ehb);
    end
    if (el[2:0] != 3'b100 && el[5:3] == 3'b100) begin
      checks++;
      if (tl.phase !== 1'b0) begin
        failures++;
        $display("FAIL phase sc=%0d k=%0d got=%b exp=0", sc, k, tl.phase);
      end
    end else if (el[5:3] != 3'b100 && el[2:0] == 3'b100) begin
      checks++;
      if (tl.phase !== 1'b1) begin
        failures++;
        $display("FAIL phase sc=%0d k=%0d got=%b exp=1", sc, k, tl.phase);
      end
    end
    nonred = int'(tl.lights[2:0] != 3'b100) + int'(tl.lights[5:3] != 3'b100);
    safe = tl.walk ? (tl.lights == R) : (nonred <= 1 || (tl.lights & 6'b101101) == 6'b0);
    checks++;
    if (safe !== 1'b1) begin
      failures++;
      $display("FAIL safety sc=%0d k=%0d lights=%b walk=%b exp safe=1", sc, k, tl.lights, tl.walk);
    end
  endtask

  task automatic do_reset();
    tl.night_mode = 1'b0;
    tl.ped_req    = 1'b0;
    tl.hold       = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset_state");
    reset = 1'b0;
    k     = 0;
  endtask

  task automatic run_vec(input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      tl.night_mode = v.night;
      tl.ped_req    = v.ped;
      tl.hold       = v.hold;
      @(posedge clk);
      @(negedge clk);
      k++;
      check_cycle(v.lights, v.walk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; k = 0; sc = 0;
    reset = 1'b1;
    tl.night_mode = 1'b0; tl.ped_req = 1'b0; tl.hold = 1'b0;

    // free run
    vecs.push_back(mk(1, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    // pedestrian pulse during dir0 green
    vecs.push_back(mk(1, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, G0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, R, 1));
    vecs.push_back(mk(0, 0, 0, 0, 12, G1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, G1, 0));
    // hold through dir0 green
    vecs.push_back(mk(1, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 1, 40, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, G1, 0));
    // night mode raised mid-yellow, then cleared
    vecs.push_back(mk(1, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, Y0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7, Y0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, F0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, F0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    // night mode and pedestrian pending together
    vecs.push_back(mk(1, 1, 1, 0, 3, R, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, R, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, F0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, F1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, F1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, R, 1));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    // run into dir0 yellow before the async reset
    vecs.push_back(mk(1, 0, 0, 0, 4, R, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, Y0, 0));

    post.push_back(mk(0, 0, 0, 0, 4, R, 0));
    post.push_back(mk(0, 0, 0, 0, 12, G0, 0));
    post.push_back(mk(0, 0, 0, 0, 8, Y0, 0));
    post.push_back(mk(0, 0, 0, 0, 4, R, 0));
    post.push_back(mk(0, 0, 0, 0, 4, G1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        sc++;
        do_reset();
      end
      run_vec(vecs[i]);
    end

    // asynchronous reset between clock edges while yellow and heartbeat are high
    #2 reset = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    check_reset("async_reset_hold");
    reset = 1'b0;
    k     = 0;
    for (int i = 0; i < post.size(); i++) begin
      run_vec(post[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
